// File: rtl/collision_ci_host.sv
// Initiator for the collision-search custom instruction: loads the message,
// launches a search, polls status and collects the digest count and collision.
module collision_ci_host #(
    parameter int RESP_TIMEOUT = 1024,
    parameter int MAX_POLLS    = 65535,
    parameter int POLL_GAP     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [31:0] target,
    output logic [2:0]  msg_pair,
    input  logic [31:0] msg_hi,
    input  logic [31:0] msg_lo,
    output logic        ci_clk_en,
    output logic        ci_reset,
    output logic        ci_start,
    output logic [31:0] ci_dataa,
    output logic [31:0] ci_datab,
    output logic [2:0]  ci_n,
    input  logic        ci_done,
    input  logic [31:0] ci_result,
    output logic        busy,
    output logic        result_valid,
    output logic        error,
    output logic [31:0] collision,
    output logic [31:0] digest_count,
    output logic [15:0] poll_count
);
    localparam int CNT_MAX = (RESP_TIMEOUT > POLL_GAP) ? RESP_TIMEOUT : POLL_GAP;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(RESP_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [15:0]   POLL_LIM = 16'(MAX_POLLS);

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SRCH = 3'd1;
    localparam logic [2:0] OP_COLL = 3'd2;
    localparam logic [2:0] OP_STAT = 3'd3;
    localparam logic [2:0] OP_CNT  = 3'd4;

    typedef enum logic [3:0] {
        IDLE, LOAD_ISSUE, LOAD_WAIT, SRCH_ISSUE, SRCH_WAIT, STAT_ISSUE, STAT_WAIT,
        CNT_ISSUE, CNT_WAIT, GAP, COLL_ISSUE, COLL_WAIT, FINISH, ABORT
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    pair, pair_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   tgt;
    logic          rst_hold;
    logic          is_wait;
    logic          is_issue_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pair_nxt  = pair;
        is_wait   = state inside {LOAD_WAIT, SRCH_WAIT, STAT_WAIT, CNT_WAIT, COLL_WAIT};
        case (state)
            IDLE: if (go) begin
                state_nxt = LOAD_ISSUE;
                pair_nxt  = 3'd0;
            end
            LOAD_ISSUE: state_nxt = LOAD_WAIT;
            LOAD_WAIT: if (ci_done) begin
                if (pair == 3'd7) begin
                    state_nxt = SRCH_ISSUE;
                end else begin
                    pair_nxt  = pair + 3'd1;
                    state_nxt = LOAD_ISSUE;
                end
            end
            SRCH_ISSUE: state_nxt = SRCH_WAIT;
            SRCH_WAIT:  if (ci_done) state_nxt = STAT_ISSUE;
            STAT_ISSUE: state_nxt = STAT_WAIT;
            STAT_WAIT: if (ci_done) begin
                if (ci_result == 32'd1)         state_nxt = COLL_ISSUE;
                else if (poll_count == POLL_LIM) state_nxt = ABORT;
                else                             state_nxt = CNT_ISSUE;
            end
            CNT_ISSUE: state_nxt = CNT_WAIT;
            CNT_WAIT: if (ci_done) state_nxt = (POLL_GAP == 0) ? STAT_ISSUE : GAP;
            GAP:        if (cnt == GAP_LAST) state_nxt = STAT_ISSUE;
            COLL_ISSUE: state_nxt = COLL_WAIT;
            COLL_WAIT:  if (ci_done) state_nxt = FINISH;
            FINISH:     state_nxt = IDLE;
            ABORT:      state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
        if (is_wait && !ci_done && cnt == TMO_LAST) state_nxt = ABORT;
    end

    assign is_issue_nxt = state_nxt inside {LOAD_ISSUE, SRCH_ISSUE, STAT_ISSUE, CNT_ISSUE, COLL_ISSUE};
    assign ci_start     = state inside {LOAD_ISSUE, SRCH_ISSUE, STAT_ISSUE, CNT_ISSUE, COLL_ISSUE};
    assign ci_clk_en    = ci_start;
    assign busy         = !(state inside {IDLE, FINISH, ABORT});
    assign result_valid = (state == FINISH);
    assign error        = (state == ABORT);
    assign ci_reset     = rst_hold | (state == ABORT);
    // Look-ahead pair so the message words are valid on the edge that loads the operands.
    assign msg_pair     = pair_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair         <= 3'd0;
            cnt          <= '0;
            tgt          <= 32'd0;
            rst_hold     <= 1'b1;
            ci_n         <= 3'd0;
            ci_dataa     <= 32'd0;
            ci_datab     <= 32'd0;
            collision    <= 32'd0;
            digest_count <= 32'd0;
            poll_count   <= 16'd0;
        end else begin
            pair <= pair_nxt;
            // One counter serves both the response timeout and the poll gap.
            if (state_nxt != state)            cnt <= '0;
            else if (is_wait || state == GAP)  cnt <= cnt + 1'b1;

            if (state == IDLE && go) begin
                tgt        <= target;
                poll_count <= 16'd0;
            end
            if (is_issue_nxt) rst_hold <= 1'b0;

            if (state_nxt != state) begin
                case (state_nxt)
                    LOAD_ISSUE: begin
                        ci_n     <= OP_LOAD;
                        ci_dataa <= msg_hi;
                        ci_datab <= msg_lo;
                    end
                    SRCH_ISSUE: begin
                        ci_n     <= OP_SRCH;
                        ci_dataa <= tgt;
                        ci_datab <= 32'd0;
                    end
                    STAT_ISSUE: begin
                        ci_n     <= OP_STAT;
                        ci_dataa <= 32'd0;
                        ci_datab <= 32'd0;
                        if (poll_count != POLL_LIM) poll_count <= poll_count + 16'd1;
                    end
                    CNT_ISSUE: begin
                        ci_n     <= OP_CNT;
                        ci_dataa <= 32'd0;
                        ci_datab <= 32'd0;
                    end
                    COLL_ISSUE: begin
                        ci_n     <= OP_COLL;
                        ci_dataa <= 32'd0;
                        ci_datab <= 32'd0;
                    end
                    default: ;
                endcase
            end

            if (ci_done && state == CNT_WAIT)  digest_count <= ci_result;
            if (ci_done && state == COLL_WAIT) collision    <= ci_result;
        end
    end
endmodule

// File: tb/tb_collision_ci_host.sv
// Directed bench for collision_ci_host with a negedge-driven responder model.
module tb_collision_ci_host;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic [31:0] target = 32'd0;
    logic [2:0]  msg_pair;
    logic [31:0] msg_hi, msg_lo;
    logic        ci_clk_en, ci_reset, ci_start;
    logic [31:0] ci_dataa, ci_datab;
    logic [2:0]  ci_n;
    logic        ci_done;
    logic [31:0] ci_result;
    logic        busy, result_valid, error;
    logic [31:0] collision, digest_count;
    logic [15:0] poll_count;

    int nvec = 0, nerr = 0, cyc = 0, go_cyc = 0;
    logic [31:0] wd [16];

    // responder configuration and state
    int          resp_delay = 0, mute_pair = -1, pcnt = 0;
    bit          spurious = 0, pend = 0;
    logic [2:0]  pn = 3'd0;
    logic [31:0] stat_q [$];
    logic [31:0] cnt_q [$];
    logic [31:0] cnt_dflt = 32'd0, coll_val = 32'd0;

    // issue log and pulse capture
    logic [2:0]  log_n [$];
    logic [31:0] log_a [$];
    logic [31:0] log_b [$];
    int          log_c [$];
    logic        log_en [$];
    int          rv_cnt = 0, rv_cyc = 0, err_cnt = 0, err_cyc = 0, busy_cnt = 0;
    logic        rv_busy = 1'b0, err_creset = 1'b0, err_busy = 1'b0;

    collision_ci_host #(.RESP_TIMEOUT(8), .MAX_POLLS(4), .POLL_GAP(2)) dut (
        .clk(clk), .reset(reset), .go(go), .target(target),
        .msg_pair(msg_pair), .msg_hi(msg_hi), .msg_lo(msg_lo),
        .ci_clk_en(ci_clk_en), .ci_reset(ci_reset), .ci_start(ci_start),
        .ci_dataa(ci_dataa), .ci_datab(ci_datab), .ci_n(ci_n),
        .ci_done(ci_done), .ci_result(ci_result),
        .busy(busy), .result_valid(result_valid), .error(error),
        .collision(collision), .digest_count(digest_count), .poll_count(poll_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign msg_hi = wd[{msg_pair, 1'b0}];
    assign msg_lo = wd[{msg_pair, 1'b1}];

    always @(negedge clk) begin
        ci_done   = 1'b0;
        ci_result = 32'd0;
        if (reset) begin
            pend = 0;
        end else begin
            if (pend) begin
                if (pcnt == 0) begin
                    ci_done = 1'b1;
                    pend    = 0;
                    case (pn)
                        3'd3:    ci_result = (stat_q.size() > 0) ? stat_q.pop_front() : 32'd0;
                        3'd4:    ci_result = (cnt_q.size() > 0) ? cnt_q.pop_front() : cnt_dflt;
                        3'd2:    ci_result = coll_val;
                        default: ci_result = 32'd0;
                    endcase
                end else begin
                    pcnt--;
                end
            end
            if (ci_start) begin
                log_n.push_back(ci_n);
                log_a.push_back(ci_dataa);
                log_b.push_back(ci_datab);
                log_c.push_back(cyc);
                log_en.push_back(ci_clk_en);
                if (!(ci_n == 3'd0 && int'(msg_pair) == mute_pair)) begin
                    pend = 1;
                    pcnt = resp_delay;
                    pn   = ci_n;
                end
                if (spurious) begin
                    ci_done   = 1'b1;
                    ci_result = 32'd1;
                    spurious  = 0;
                end
            end
            if (result_valid) begin rv_cnt++; rv_cyc = cyc; rv_busy = busy; end
            if (error) begin err_cnt++; err_cyc = cyc; err_creset = ci_reset; err_busy = busy; end
            if (busy) busy_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int cnt_op(input logic [2:0] op);
        int c = 0;
        foreach (log_n[i]) if (log_n[i] == op) c++;
        return c;
    endfunction

    task automatic start_job(input logic [31:0] tgt);
        log_n.delete(); log_a.delete(); log_b.delete(); log_c.delete(); log_en.delete();
        rv_cnt = 0; err_cnt = 0; busy_cnt = 0;
        tick();
        target = tgt;
        go     = 1'b1;
        tick();
        go     = 1'b0;
        go_cyc = cyc;
    endtask

    task automatic wait_job(output int rel);
        int n = 0;
        while (rv_cnt == 0 && err_cnt == 0 && n < 300) begin
            tick();
            n++;
        end
        chk("job_end_pulses", 32'(rv_cnt + err_cnt), 1);
        rel = (rv_cnt != 0) ? rv_cyc - go_cyc + 1 : err_cyc - go_cyc + 1;
    endtask

    initial begin
        int rel, n;
        for (int i = 0; i < 16; i++) wd[i] = 32'h58585858 + 32'h01010101 * i;

        // reset state
        tick(); tick();
        chk("rst_ci_reset", 32'(ci_reset), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ci_start", 32'(ci_start), 0);
        chk("rst_ci_clk_en", 32'(ci_clk_en), 0);
        chk("rst_rv_err", 32'({result_valid, error}), 0);
        chk("rst_regs", 32'({ci_n, poll_count}) | ci_dataa | collision | digest_count, 0);
        reset = 1'b0;
        tick();
        chk("rel_ci_reset_held", 32'(ci_reset), 1);

        // load order + best-case latency
        resp_delay = 0;
        stat_q = '{32'd1};
        coll_val = 32'hA5A50001;
        start_job(32'd5);
        wait_job(rel);
        chk("t3_rv_latency", 32'(rel), 23);
        chk("t3_busy_cycles", 32'(busy_cnt), 22);
        chk("t3_busy_at_rv", 32'(rv_busy), 0);
        chk("t1_issue_count", 32'(log_n.size()), 11);
        if (log_n.size() >= 11) begin
            for (int k = 0; k < 8; k++) begin
                chk("t1_ld_n", 32'(log_n[k]), 0);
                chk("t1_ld_a", log_a[k], 32'h58585858 + 32'h01010101 * (2 * k));
                chk("t1_ld_b", log_b[k], 32'h58585858 + 32'h01010101 * (2 * k + 1));
                chk("t1_ld_en", 32'(log_en[k]), 1);
            end
            chk("t1_srch_n", 32'(log_n[8]), 1);
            chk("t1_srch_a", log_a[8], 32'd5);
            chk("t1_srch_b", log_b[8], 32'd0);
            chk("t1_stat_n", 32'(log_n[9]), 3);
            chk("t1_coll_n", 32'(log_n[10]), 2);
        end
        chk("t1_collision", collision, 32'hA5A50001);
        chk("t1_poll_count", 32'(poll_count), 1);
        chk("t1_digest", digest_count, 0);
        chk("t1_ci_reset_low", 32'(ci_reset), 0);

        // polling loop
        stat_q = '{32'd0, 32'd0, 32'd1};
        cnt_q = '{32'd100, 32'd200};
        coll_val = 32'h1234ABCD;
        start_job(32'h77);
        wait_job(rel);
        chk("t2_latency", 32'(rel), 35);
        chk("t2_poll_count", 32'(poll_count), 3);
        chk("t2_digest", digest_count, 32'd200);
        chk("t2_collision", collision, 32'h1234ABCD);
        chk("t2_stat_issues", 32'(cnt_op(3'd3)), 3);
        chk("t2_cnt_issues", 32'(cnt_op(3'd4)), 2);
        chk("t2_coll_issues", 32'(cnt_op(3'd2)), 1);
        tick(); tick();
        chk("t2_rv_pulses", 32'(rv_cnt), 1);
        chk("t2_err_pulses", 32'(err_cnt), 0);

        // response timeout on pair 3
        mute_pair = 3;
        start_job(32'd1);
        wait_job(rel);
        chk("t4_err_latency", 32'(rel), 16);
        chk("t4_err_pulses", 32'(err_cnt), 1);
        chk("t4_ci_reset_pulse", 32'(err_creset), 1);
        chk("t4_busy_at_err", 32'(err_busy), 0);
        chk("t4_issues", 32'(log_n.size()), 4);
        chk("t4_poll_count", 32'(poll_count), 0);
        tick();
        chk("t4_ci_reset_after", 32'(ci_reset), 0);
        chk("t4_idle", 32'({busy, error, result_valid}), 0);
        mute_pair = -1;

        // poll limit
        stat_q.delete();
        cnt_dflt = 32'd7;
        start_job(32'd2);
        wait_job(rel);
        chk("t5_err_latency", 32'(rel), 39);
        chk("t5_err_pulses", 32'(err_cnt), 1);
        chk("t5_stat_issues", 32'(cnt_op(3'd3)), 4);
        chk("t5_poll_count", 32'(poll_count), 4);
        chk("t5_digest", digest_count, 32'd7);
        chk("t5_collision_kept", collision, 32'h1234ABCD);

        // spurious done, go while busy, reset mid search
        resp_delay = 2;
        spurious = 1;
        start_job(32'd3);
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        n = 0;
        while (cnt_op(3'd1) == 0 && n < 100) begin tick(); n++; end
        chk("t6_srch_seen", 32'(cnt_op(3'd1)), 1);
        chk("t6_loads", 32'(cnt_op(3'd0)), 8);
        if (log_c.size() >= 9) begin
            chk("t6_ld1_rel", 32'(log_c[1] - go_cyc + 1), 5);
            chk("t6_srch_rel", 32'(log_c[8] - go_cyc + 1), 33);
        end
        tick();
        chk("t6_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_start_en", 32'({ci_start, ci_clk_en}), 0);
        chk("t6_ci_reset", 32'(ci_reset), 1);
        chk("t6_collision", collision, 0);
        chk("t6_digest", digest_count, 0);
        chk("t6_rv_err_poll", 32'({result_valid, error, poll_count}), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_ci_reset_held", 32'(ci_reset), 1);
        chk("t6_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
